// File: rtl/array_30_ctrl.sv
// array_30_ctrl: valid/ready front-end for a byte-masked single-port array, owning its RW0 pins.
// Define ARRAY_30_CTRL_INIT_EN to zero-fill the array after reset before accepting requests.
module array_30_ctrl #(
  parameter int  DEPTH     = 256,
  parameter int  WIDTH     = 48,
  parameter int  MASK_GRAN = 8,
  localparam int MASK_SEG  = WIDTH / MASK_GRAN,
  localparam int ADDR_W    = $clog2(DEPTH)
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [MASK_SEG-1:0] req_mask,
  input  logic [WIDTH-1:0]    req_wdata,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [WIDTH-1:0]    resp_data,
  output logic                init_done,
  output logic [ADDR_W-1:0]   arr_addr,
  output logic                arr_en,
  output logic                arr_wmode,
  output logic [MASK_SEG-1:0] arr_wmask,
  output logic [WIDTH-1:0]    arr_wdata,
  input  logic [WIDTH-1:0]    arr_rdata
);

  logic [1:0]       count_q, count_d;
  logic             inflight_q, inflight_d;
  logic             head_q, head_d;
  logic [WIDTH-1:0] q_q [2];
  logic [WIDTH-1:0] q_d [2];
  logic             idle;
  logic             req_fire;
  logic             resp_fire;
  logic [2:0]       occ;

`ifdef ARRAY_30_CTRL_INIT_EN
  // state   | meaning
  // ST_INIT | zero-filling the array, one entry per cycle, requests blocked
  // ST_IDLE | normal request service; left only by reset
  typedef enum logic {ST_INIT, ST_IDLE} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (state_q == ST_INIT) begin
      idx_d = idx_q + ADDR_W'(1);
      if (idx_q == ADDR_W'(DEPTH - 1)) state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_INIT;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  assign idle = (state_q == ST_IDLE);
`else
  assign idle = 1'b1;
`endif

  assign init_done = idle;

  // Ready must not depend on req_write, so writes share the read occupancy rule.
  always_comb begin
    resp_valid = (count_q != 2'd0);
    resp_data  = q_q[head_q];
    resp_fire  = resp_valid & resp_ready;
    occ        = 3'(count_q) + 3'(inflight_q);
    req_ready  = idle & ((occ < 3'd2) | resp_fire);
    req_fire   = req_valid & req_ready;
  end

  always_comb begin
    arr_en    = 1'b0;
    arr_wmode = 1'b0;
    arr_addr  = '0;
    arr_wmask = '0;
    arr_wdata = '0;
    if (req_fire) begin
      arr_en    = 1'b1;
      arr_wmode = req_write;
      arr_addr  = req_addr;
      arr_wmask = req_mask;
      arr_wdata = req_wdata;
    end
`ifdef ARRAY_30_CTRL_INIT_EN
    if (state_q == ST_INIT) begin
      arr_en    = 1'b1;
      arr_wmode = 1'b1;
      arr_addr  = idx_q;
      arr_wmask = '1;
      arr_wdata = '0;
    end
`endif
  end

  // Read data lands one cycle after the fire; it is written behind the current tail.
  always_comb begin
    q_d[0]     = q_q[0];
    q_d[1]     = q_q[1];
    head_d     = head_q;
    count_d    = count_q;
    inflight_d = req_fire & ~req_write;
    if (inflight_q) q_d[head_q ^ count_q[0]] = arr_rdata;
    if (resp_fire) head_d = ~head_q;
    case ({inflight_q, resp_fire})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q_q[0]     <= '0;
      q_q[1]     <= '0;
      head_q     <= 1'b0;
      count_q    <= 2'd0;
      inflight_q <= 1'b0;
    end else begin
      q_q[0]     <= q_d[0];
      q_q[1]     <= q_d[1];
      head_q     <= head_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
    end
  end

endmodule

// File: tb/tb_array_30_ctrl.sv
// Bench for array_30_ctrl: behavioural array model, queue-based scoreboard and directed traffic.
module tb_array_30_ctrl;
  localparam int WIDTH    = 48;
  localparam int DEPTH    = 256;
  localparam int ADDR_W   = 8;
  localparam int MASK_SEG = 6;

  logic                clock = 1'b0;
  logic                reset_n;
  logic                req_valid, req_ready, req_write;
  logic [ADDR_W-1:0]   req_addr;
  logic [MASK_SEG-1:0] req_mask;
  logic [WIDTH-1:0]    req_wdata;
  logic                resp_valid, resp_ready;
  logic [WIDTH-1:0]    resp_data;
  logic                init_done;
  logic [ADDR_W-1:0]   arr_addr;
  logic                arr_en, arr_wmode;
  logic [MASK_SEG-1:0] arr_wmask;
  logic [WIDTH-1:0]    arr_wdata;
  logic [WIDTH-1:0]    arr_rdata;

  always #5 clock = ~clock;

  array_30_ctrl dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_mask   (req_mask),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .init_done  (init_done),
    .arr_addr   (arr_addr),
    .arr_en     (arr_en),
    .arr_wmode  (arr_wmode),
    .arr_wmask  (arr_wmask),
    .arr_wdata  (arr_wdata),
    .arr_rdata  (arr_rdata)
  );

  // Array model: byte-masked writes, read data registered one cycle late.
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_r = '0;
  logic             filled = 1'b0;
  assign arr_rdata = rdata_r;

  always @(posedge clock) begin
    if (!filled) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 48'h5A5A_5A5A_5A5A;
      filled <= 1'b1;
    end else if (arr_en) begin
      if (arr_wmode) begin
        for (int l = 0; l < MASK_SEG; l++)
          if (arr_wmask[l]) mem[arr_addr][l*8 +: 8] <= arr_wdata[l*8 +: 8];
      end else begin
        rdata_r <= mem[arr_addr];
      end
    end
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [WIDTH-1:0] data;
    int               cyc;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] sd(input int i);
    return {16'h5EED, 8'(i), 8'(8'hF0 ^ 8'(i)), 16'h1000 + 16'(i)};
  endfunction

  // Monitor: every accepted response is matched against the oldest expectation.
  always @(negedge clock) begin
    if (reset_n && resp_valid && resp_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_resp: got %0h expected none", resp_data);
      end else begin
        mon_e = sb.pop_front();
        check("resp_data", 64'(resp_data), 64'(mon_e.data));
        if (mon_e.cyc >= 0) check("resp_cycle", 64'(cyc), 64'(mon_e.cyc));
      end
    end
  end

  // Called just after a rising edge; returns just after the edge that ends the request.
  task automatic do_req(input logic wr, input logic [ADDR_W-1:0] a, input logic [MASK_SEG-1:0] m,
                        input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] exp, input bit timed,
                        output int acc_cyc);
    int waited;
    bit done;
    waited = 0;
    done = 1'b0;
    acc_cyc = -1;
    req_valid = 1'b1; req_write = wr; req_addr = a; req_mask = m; req_wdata = d;
    while (!done) begin
      @(negedge clock);
      if (req_ready) begin
        done = 1'b1;
        acc_cyc = cyc;
        check("arr_en_on_fire", 64'(arr_en), 64'd1);
        check("arr_addr_on_fire", 64'(arr_addr), 64'(a));
        check("arr_wmode_on_fire", 64'(arr_wmode), 64'(wr));
        if (wr) begin
          check("arr_wmask_on_fire", 64'(arr_wmask), 64'(m));
          check("arr_wdata_on_fire", 64'(arr_wdata), 64'(d));
        end else begin
          sb.push_back('{data: exp, cyc: (timed ? cyc + 2 : -1)});
        end
      end else begin
        waited++;
        if (waited > 40) begin
          checks++;
          failures++;
          $display("FAIL req_timeout: got req_ready=0 for %0d cycles expected acceptance", waited);
          done = 1'b1;
        end
      end
      @(posedge clock); #1;
    end
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_mask = '0; req_wdata = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int n0;
    int nacc;
    int waited;
    reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_mask = '0; req_wdata = '0; resp_ready = 1'b0;

    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_data", 64'(resp_data), 64'd0);
    check("rst_arr_en", 64'(arr_en), 64'd0);
    check("rst_arr_addr", 64'(arr_addr), 64'd0);
    check("rst_arr_wdata", 64'(arr_wdata), 64'd0);
    check("rst_arr_wmask", 64'(arr_wmask), 64'd0);
`ifdef ARRAY_30_CTRL_INIT_EN
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_init_done", 64'(init_done), 64'd0);
`else
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_init_done", 64'(init_done), 64'd1);
`endif
    @(posedge clock); #1;
    reset_n = 1'b1;
    resp_ready = 1'b1;

`ifdef ARRAY_30_CTRL_INIT_EN
    @(negedge clock);
    check("init_first_en", 64'(arr_en), 64'd1);
    check("init_first_addr", 64'(arr_addr), 64'd0);
    check("init_first_wmask", 64'(arr_wmask), 64'h3F);
    check("init_first_wdata", 64'(arr_wdata), 64'd0);
    check("init_ready_low", 64'(req_ready), 64'd0);
    repeat (255) @(posedge clock);
    @(negedge clock);
    check("init_last_addr", 64'(arr_addr), 64'd255);
    check("init_done_before", 64'(init_done), 64'd0);
    @(posedge clock);
    @(negedge clock);
    check("init_done_at_256", 64'(init_done), 64'd1);
    check("init_ready_at_256", 64'(req_ready), 64'd1);
    @(posedge clock); #1;
    do_req(1'b0, 8'h00, '0, '0, 48'h0, 1'b1, acc);
    do_req(1'b0, 8'h7F, '0, '0, 48'h0, 1'b1, acc);
    do_req(1'b0, 8'hFF, '0, '0, 48'h0, 1'b1, acc);
`else
    @(negedge clock);
    check("noinit_done", 64'(init_done), 64'd1);
    check("noinit_ready", 64'(req_ready), 64'd1);
    check("noinit_idle_en", 64'(arr_en), 64'd0);
    @(posedge clock); #1;
`endif

    // Byte-masked writes, including an all-zero mask that must change nothing
    do_req(1'b1, 8'h12, 6'b111111, 48'hAABB_CCDD_EEFF, '0, 1'b0, acc);
    do_req(1'b1, 8'h12, 6'b000101, 48'h1122_3344_5566, '0, 1'b0, acc);
    do_req(1'b0, 8'h12, '0, '0, 48'hAABB_CC44_EE66, 1'b1, acc);
    do_req(1'b1, 8'h12, 6'b000000, 48'hFFFF_FFFF_FFFF, '0, 1'b0, acc);
    do_req(1'b0, 8'h12, '0, '0, 48'hAABB_CC44_EE66, 1'b1, acc);

    // Streaming reads
    for (int i = 0; i < 8; i++) do_req(1'b1, 8'(i), 6'h3F, sd(i), '0, 1'b0, acc);
    for (int i = 0; i < 8; i++) begin
      do_req(1'b0, 8'(i), '0, '0, sd(i), 1'b1, acc);
      if (i == 0) n0 = acc;
      else check("stream_back_to_back", 64'(acc), 64'(n0 + i));
    end
    repeat (4) @(posedge clock); #1;

    // Backpressure: only two reads fit, then a pop frees a slot in the same cycle
    resp_ready = 1'b0;
    nacc = 0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'd0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      if (req_ready) begin
        sb.push_back('{data: sd(nacc), cyc: -1});
        nacc++;
      end
      @(posedge clock); #1;
      req_addr = 8'(nacc);
    end
    check("bp_accepted", 64'(nacc), 64'd2);
    @(negedge clock);
    check("bp_ready_low", 64'(req_ready), 64'd0);
    @(posedge clock); #1;
    resp_ready = 1'b1;
    @(negedge clock);
    check("bp_ready_on_pop", 64'(req_ready), 64'd1);
    if (req_ready) sb.push_back('{data: sd(nacc), cyc: -1});
    @(posedge clock); #1;
    req_valid = 1'b0; req_addr = '0;
    repeat (5) @(posedge clock); #1;

    // Read followed immediately by a write to the same address
    do_req(1'b1, 8'h40, 6'h3F, 48'h1, '0, 1'b0, acc);
    do_req(1'b0, 8'h40, '0, '0, 48'h1, 1'b1, acc);
    do_req(1'b1, 8'h40, 6'h3F, 48'h2, '0, 1'b0, acc);
    do_req(1'b0, 8'h40, '0, '0, 48'h2, 1'b1, acc);
    repeat (4) @(posedge clock); #1;

    // Reset with one response queued and a read in flight
    resp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'd3;
    @(negedge clock);
    check("rst_setup_ready0", 64'(req_ready), 64'd1);
    @(posedge clock); #1;
    req_addr = 8'd4;
    @(negedge clock);
    check("rst_setup_ready1", 64'(req_ready), 64'd1);
    @(posedge clock); #1;
    req_valid = 1'b0; req_addr = '0;
    @(negedge clock);
    check("pre_reset_valid", 64'(resp_valid), 64'd1);
    reset_n = 1'b0;
    #1;
    check("reset_drops_valid", 64'(resp_valid), 64'd0);
    check("reset_drops_data", 64'(resp_data), 64'd0);
    sb.delete();
    @(posedge clock); #1;
    reset_n = 1'b1;
    resp_ready = 1'b1;
`ifdef ARRAY_30_CTRL_INIT_EN
    @(negedge clock);
    check("reinit_addr", 64'(arr_addr), 64'd0);
    check("reinit_en", 64'(arr_en), 64'd1);
    check("reinit_done_low", 64'(init_done), 64'd0);
    repeat (256) @(posedge clock);
    @(negedge clock);
    check("reinit_done", 64'(init_done), 64'd1);
    check("no_stale_resp", 64'(resp_valid), 64'd0);
    @(posedge clock); #1;
    do_req(1'b0, 8'h40, '0, '0, 48'h0, 1'b1, acc);
`else
    repeat (4) @(posedge clock);
    @(negedge clock);
    check("no_stale_resp", 64'(resp_valid), 64'd0);
    @(posedge clock); #1;
    do_req(1'b0, 8'h40, '0, '0, 48'h2, 1'b1, acc);
`endif

    waited = 0;
    while (sb.size() != 0 && waited < 20) begin
      @(posedge clock);
      waited++;
    end
    @(negedge clock);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
